// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN_D, OWN_I} arb_state_t;

  localparam int GNT_D = 0;
  localparam int GNT_I = 1;
  localparam int CNT_W = 4;

  // One-hot owner vector for a given arbiter state.
  function automatic logic [1:0] state_grant(arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    if (s == OWN_D) g[GNT_D] = 1'b1;
    if (s == OWN_I) g[GNT_I] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/wb_mux2.sv
// Combinational request/response steering between two masters and one slave,
// selected by the one-hot grant vector.
module wb_mux2
  import wb_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        i_grant,
  // data master request
  input  logic              i_d_cyc,
  input  logic              i_d_stb,
  input  logic              i_d_we,
  input  logic [XLEN-1:0]   i_d_adr,
  input  logic [XLEN/8-1:0] i_d_sel,
  input  logic [XLEN-1:0]   i_d_dat_w,
  // instr master request
  input  logic              i_i_cyc,
  input  logic              i_i_stb,
  input  logic              i_i_we,
  input  logic [XLEN-1:0]   i_i_adr,
  input  logic [XLEN/8-1:0] i_i_sel,
  input  logic [XLEN-1:0]   i_i_dat_w,
  // slave side
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [XLEN-1:0]   o_s_adr,
  output logic [XLEN/8-1:0] o_s_sel,
  output logic [XLEN-1:0]   o_s_dat_w,
  input  logic [XLEN-1:0]   i_s_dat_r,
  input  logic              i_s_ack,
  // responses back to masters
  output logic [XLEN-1:0]   o_d_dat_r,
  output logic              o_d_ack,
  output logic [XLEN-1:0]   o_i_dat_r,
  output logic              o_i_ack
);

  // Forward the owner's request, gated by its cyc so a release is seen by
  // the slave in the same cycle; everything is zero when nobody owns the bus.
  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_adr   = '0;
    o_s_sel   = '0;
    o_s_dat_w = '0;
    if (i_grant[GNT_D] && i_d_cyc) begin
      o_s_cyc   = 1'b1;
      o_s_stb   = i_d_stb;
      o_s_we    = i_d_we;
      o_s_adr   = i_d_adr;
      o_s_sel   = i_d_sel;
      o_s_dat_w = i_d_dat_w;
    end else if (i_grant[GNT_I] && i_i_cyc) begin
      o_s_cyc   = 1'b1;
      o_s_stb   = i_i_stb;
      o_s_we    = i_i_we;
      o_s_adr   = i_i_adr;
      o_s_sel   = i_i_sel;
      o_s_dat_w = i_i_dat_w;
    end
  end

  // Read data is broadcast; ack reaches only the owner so the other master stalls.
  assign o_d_dat_r = i_s_dat_r;
  assign o_i_dat_r = i_s_dat_r;
  assign o_d_ack   = i_grant[GNT_D] & i_s_ack;
  assign o_i_ack   = i_grant[GNT_I] & i_s_ack;

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: data has fixed priority, a starvation counter
// lets a pending fetch win after STARVE_LIMIT contested data grants.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // data master (core.data_bus)
  input  logic              i_d_cyc,
  input  logic              i_d_stb,
  input  logic              i_d_we,
  input  logic [XLEN-1:0]   i_d_adr,
  input  logic [XLEN/8-1:0] i_d_sel,
  input  logic [XLEN-1:0]   i_d_dat_w,
  output logic [XLEN-1:0]   o_d_dat_r,
  output logic              o_d_ack,
  // instr master (core.instr_bus)
  input  logic              i_i_cyc,
  input  logic              i_i_stb,
  input  logic              i_i_we,
  input  logic [XLEN-1:0]   i_i_adr,
  input  logic [XLEN/8-1:0] i_i_sel,
  input  logic [XLEN-1:0]   i_i_dat_w,
  output logic [XLEN-1:0]   o_i_dat_r,
  output logic              o_i_ack,
  // shared slave port
  output logic              o_s_cyc,
  output logic              o_s_stb,
  output logic              o_s_we,
  output logic [XLEN-1:0]   o_s_adr,
  output logic [XLEN/8-1:0] o_s_sel,
  output logic [XLEN-1:0]   o_s_dat_w,
  input  logic [XLEN-1:0]   i_s_dat_r,
  input  logic              i_s_ack,
  // status
  output logic [1:0]        o_grant,
  output logic [CNT_W-1:0]  o_starve_cnt
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state;
  logic [1:0]       r_grant;
  logic [CNT_W-1:0] r_starve;

  logic       w_arb;
  arb_state_t w_nxt;

  // Arbitrate when idle or on the cycle the current owner drops cyc.
  always_comb begin
    w_arb = (r_state == IDLE) ||
            (r_state == OWN_D && !i_d_cyc) ||
            (r_state == OWN_I && !i_i_cyc);
    w_nxt = r_state;
    if (w_arb) begin
      if (i_d_cyc && i_i_cyc) w_nxt = (r_starve == LIM) ? OWN_I : OWN_D;
      else if (i_d_cyc)       w_nxt = OWN_D;
      else if (i_i_cyc)       w_nxt = OWN_I;
      else                    w_nxt = IDLE;
    end
  end

  // Owner FSM with registered grant and the fetch starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= 2'b00;
      r_starve <= '0;
    end else begin
      r_state <= w_nxt;
      r_grant <= state_grant(w_nxt);
      if (w_arb && w_nxt == OWN_I)
        r_starve <= '0;
      else if (w_arb && w_nxt == OWN_D && i_i_cyc) begin
        if (r_starve != LIM) r_starve <= r_starve + 1'b1;
      end else if (r_state == IDLE && !i_i_cyc)
        r_starve <= '0;
    end
  end

  assign o_grant      = r_grant;
  assign o_starve_cnt = r_starve;

  wb_mux2 #(.XLEN(XLEN)) u_mux (
    .i_grant   (r_grant),
    .i_d_cyc   (i_d_cyc),
    .i_d_stb   (i_d_stb),
    .i_d_we    (i_d_we),
    .i_d_adr   (i_d_adr),
    .i_d_sel   (i_d_sel),
    .i_d_dat_w (i_d_dat_w),
    .i_i_cyc   (i_i_cyc),
    .i_i_stb   (i_i_stb),
    .i_i_we    (i_i_we),
    .i_i_adr   (i_i_adr),
    .i_i_sel   (i_i_sel),
    .i_i_dat_w (i_i_dat_w),
    .o_s_cyc   (o_s_cyc),
    .o_s_stb   (o_s_stb),
    .o_s_we    (o_s_we),
    .o_s_adr   (o_s_adr),
    .o_s_sel   (o_s_sel),
    .o_s_dat_w (o_s_dat_w),
    .i_s_dat_r (i_s_dat_r),
    .i_s_ack   (i_s_ack),
    .o_d_dat_r (o_d_dat_r),
    .o_d_ack   (o_d_ack),
    .o_i_dat_r (o_i_dat_r),
    .o_i_ack   (o_i_ack)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter plus hand-written corner sequences.
module tb_wb_arbiter;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic d_cyc, d_stb, d_we, i_cyc, i_stb, i_we, s_ack;
  logic [XLEN-1:0] d_adr, d_dat_w, i_adr, i_dat_w, s_dat_r;
  logic [3:0] d_sel, i_sel;
  logic [XLEN-1:0] d_dat_r, i_dat_r, s_adr, s_dat_w;
  logic d_ack, i_ack, s_cyc, s_stb, s_we;
  logic [3:0] s_sel, starve;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_d_cyc(d_cyc), .i_d_stb(d_stb), .i_d_we(d_we), .i_d_adr(d_adr),
    .i_d_sel(d_sel), .i_d_dat_w(d_dat_w), .o_d_dat_r(d_dat_r), .o_d_ack(d_ack),
    .i_i_cyc(i_cyc), .i_i_stb(i_stb), .i_i_we(i_we), .i_i_adr(i_adr),
    .i_i_sel(i_sel), .i_i_dat_w(i_dat_w), .o_i_dat_r(i_dat_r), .o_i_ack(i_ack),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
    .o_s_sel(s_sel), .o_s_dat_w(s_dat_w), .i_s_dat_r(s_dat_r), .i_s_ack(s_ack),
    .o_grant(grant), .o_starve_cnt(starve)
  );

  typedef struct {
    logic        d, i, ack;
    logic [1:0]  g;
    logic        scyc;
    logic [31:0] adr;
    logic        dack, iack;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic d, logic i, logic ack, logic [1:0] g, logic scyc,
                              logic [31:0] adr, logic dack, logic iack, logic [3:0] cnt);
    vec_t v;
    v.d = d; v.i = i; v.ack = ack; v.g = g; v.scyc = scyc;
    v.adr = adr; v.dack = dack; v.iack = iack; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic d, input logic i, input logic ack);
    d_cyc = d; d_stb = d; i_cyc = i; i_stb = i; s_ack = ack;
  endtask

  // advance one clock; inputs change 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0);
    d_we = 1'b1; d_adr = 32'h100; d_sel = 4'hF; d_dat_w = 32'h1111_1111;
    i_we = 1'b0; i_adr = 32'h200; i_sel = 4'hF; i_dat_w = 32'h0;
    s_dat_r = 32'hDEAD_BEEF;

    //          d  i  ack g      scyc adr     dack iack cnt
    tbl[0]  = mk(0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0); // idle
    tbl[1]  = mk(1, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0); // data request seen
    tbl[2]  = mk(1, 0, 0, 2'b01, 1, 32'h100, 0, 0, 0); // granted next cycle
    tbl[3]  = mk(1, 0, 1, 2'b01, 1, 32'h100, 1, 0, 0); // slave ack second cycle
    tbl[4]  = mk(0, 0, 0, 2'b01, 0, 32'h0,   0, 0, 0); // release gates cyc
    tbl[5]  = mk(1, 1, 0, 2'b00, 0, 32'h0,   0, 0, 0); // simultaneous request
    tbl[6]  = mk(1, 1, 1, 2'b01, 1, 32'h100, 1, 0, 1); // data wins, instr waits
    tbl[7]  = mk(0, 1, 0, 2'b01, 0, 32'h0,   0, 0, 1); // data drops, handover
    tbl[8]  = mk(0, 1, 1, 2'b10, 1, 32'h200, 0, 1, 0); // instr burst beat 1
    tbl[9]  = mk(1, 1, 1, 2'b10, 1, 32'h200, 0, 1, 0); // data asks mid-burst
    tbl[10] = mk(1, 1, 1, 2'b10, 1, 32'h200, 0, 1, 0); // beat 3, no preemption
    tbl[11] = mk(1, 0, 0, 2'b10, 0, 32'h0,   0, 0, 0); // instr releases
    tbl[12] = mk(1, 0, 0, 2'b01, 1, 32'h100, 0, 0, 0); // data back-to-back
    tbl[13] = mk(0, 0, 0, 2'b01, 0, 32'h0,   0, 0, 0);
    tbl[14] = mk(0, 0, 0, 2'b00, 0, 32'h0,   0, 0, 0);

    // reset state
    #12;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_bus", {s_stb, s_we, s_adr, s_sel, s_dat_w}, 0);
    chk("rst_acks", {d_ack, i_ack}, 0);
    chk("rst_grant", grant, 0);
    chk("rst_starve", starve, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // table vectors
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].d, tbl[k].i, tbl[k].ack);
      #1;
      chk($sformatf("v%0d_grant", k), grant, tbl[k].g);
      chk($sformatf("v%0d_s_cyc", k), s_cyc, tbl[k].scyc);
      chk($sformatf("v%0d_s_adr", k), s_adr, tbl[k].adr);
      chk($sformatf("v%0d_d_ack", k), d_ack, tbl[k].dack);
      chk($sformatf("v%0d_i_ack", k), i_ack, tbl[k].iack);
      chk($sformatf("v%0d_starve", k), starve, tbl[k].cnt);
      if (k == 3) begin
        chk("rd_d_dat_r", d_dat_r, 32'hDEAD_BEEF);
        chk("rd_i_dat_r", i_dat_r, 32'hDEAD_BEEF);
        chk("rd_s_we_sel", {s_we, s_sel}, 5'h1F);
        chk("rd_s_dat_w", s_dat_w, 32'h1111_1111);
      end
      if (k == 8) chk("burst_s_we", s_we, 0);
      tick();
    end

    // starvation: four contested data grants, fifth arbitration goes to instr
    for (int g = 1; g <= 4; g++) begin
      drive(1, 1, 0); #1;
      chk($sformatf("st%0d_idle_grant", g), grant, 2'b00);
      tick();
      drive(1, 0, 1); #1;
      chk($sformatf("st%0d_grant", g), grant, 2'b01);
      chk($sformatf("st%0d_cnt", g), starve, 4'(g));
      chk($sformatf("st%0d_d_ack", g), d_ack, 1);
      tick();
      drive(0, 0, 0); #1;
      chk($sformatf("st%0d_rel_cyc", g), s_cyc, 0);
      tick();
    end
    drive(1, 1, 0); #1;
    chk("st5_cnt_sat", starve, 4);
    tick();
    drive(1, 1, 1); #1;
    chk("st5_grant_i", grant, 2'b10);
    chk("st5_cnt_clr", starve, 0);
    chk("st5_adr", s_adr, 32'h200);
    chk("st5_acks", {d_ack, i_ack}, 2'b01);
    tick();
    drive(1, 0, 0); tick();
    #1 chk("st_after_grant_d", grant, 2'b01);
    drive(0, 0, 0); tick();

    // reset while data owns the bus with stb high
    drive(1, 0, 0); tick();
    s_ack = 1'b1; #1;
    chk("mr_pre_grant", grant, 2'b01);
    chk("mr_pre_cyc", {s_cyc, s_stb, d_ack}, 3'b111);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_cyc_async", {s_cyc, s_stb}, 2'b00);
    chk("mr_grant_async", grant, 2'b00);
    chk("mr_ack_async", d_ack, 0);
    chk("mr_adr_async", s_adr, 0);
    @(posedge clk);
    #2 rst_n = 1'b1; s_ack = 1'b0;
    #1 chk("mr_post_idle", grant, 2'b00);
    tick();
    #1;
    chk("mr_retry_grant", grant, 2'b01);
    chk("mr_retry_cyc", s_cyc, 1);
    drive(0, 0, 0); tick();
    tick();

    // idle for ten cycles
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("idle%0d_bus", c), {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w}, 0);
      chk($sformatf("idle%0d_grant", c), grant, 0);
      chk($sformatf("idle%0d_cnt", c), starve, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
